// File: rtl/tilemap_pkg.sv
// Shared tile codes, FSM encoding and code width for the tilemap renderer.
package tilemap_pkg;

  localparam int unsigned CODE_W = 2;

  localparam logic [CODE_W-1:0] FLOOR       = 2'd0;
  localparam logic [CODE_W-1:0] WALL        = 2'd1;
  localparam logic [CODE_W-1:0] DOOR_LOCKED = 2'd2;
  localparam logic [CODE_W-1:0] DOOR_OPEN   = 2'd3;

  typedef enum logic {
    INIT,
    RUN
  } fsm_t;

endpackage

// File: rtl/tilemap_rom.sv
// Default stage layout: outer wall ring, pillar grid every 3 cells leaving
// 2-wide corridors, and a 3-cell exit gap centred on the east wall.
module tilemap_rom
  import tilemap_pkg::*;
#(
  parameter int unsigned MAP_W = 41,
  parameter int unsigned MAP_H = 41
) (
  input  logic [$clog2(MAP_W*MAP_H)-1:0] idx,
  output logic [CODE_W-1:0]              code
);

  localparam int unsigned IW     = $clog2(MAP_W * MAP_H);
  localparam int unsigned GAP_LO = MAP_H / 2 - 1;
  localparam int unsigned GAP_HI = MAP_H / 2 + 1;

  logic [IW-1:0] cx;
  logic [IW-1:0] cy;
  logic          border;
  logic          gap;
  logic          pillar;

  always_comb begin
    cx     = IW'(idx % IW'(MAP_W));
    cy     = IW'(idx / IW'(MAP_W));
    border = (cx == '0) || (cy == '0) ||
             (cx == IW'(MAP_W - 1)) || (cy == IW'(MAP_H - 1));
    gap    = (cx == IW'(MAP_W - 1)) && (cy >= IW'(GAP_LO)) && (cy <= IW'(GAP_HI));
    pillar = ((cx % IW'(3)) == '0) && ((cy % IW'(3)) == '0);
    code   = FLOOR;
    if (!gap && (border || pillar)) code = WALL;
  end

endmodule

// File: rtl/draw_tilemap.sv
// Writable tile-map renderer: RAM-backed MAP_W x MAP_H grid loaded from the
// default layout after reset, producing texture addresses with 2-cycle latency.
module draw_tilemap
  import tilemap_pkg::*;
#(
  parameter int unsigned MAP_W       = 41,
  parameter int unsigned MAP_H       = 41,
  parameter int unsigned TILE        = 5,
  parameter int unsigned SCALE_SHIFT = 1,
  parameter int unsigned ORG_X       = 60,
  parameter int unsigned ORG_Y       = 30,
  parameter int unsigned TEX_W       = 360,
  parameter int unsigned TEX_BASE_X  = 330,
  parameter int unsigned TEX_BASE_Y  = 30,
  parameter int unsigned TEX_DEPTH   = 86400,
  parameter logic [15:0] STAGE_MASK  = 16'h0054
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [3:0]                 state,
  input  logic [9:0]                 h_cnt,
  input  logic [9:0]                 v_cnt,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [$clog2(MAP_W)-1:0]   wr_x,
  input  logic [$clog2(MAP_H)-1:0]   wr_y,
  input  logic [CODE_W-1:0]          wr_tile,
  output logic                       wr_err,
  output logic                       init_done,
  output logic [16:0]                pixel_addr,
  output logic                       isObject
);

  localparam int unsigned CELLS = MAP_W * MAP_H;
  localparam int unsigned IW    = $clog2(CELLS);
  localparam int unsigned AW    = 20;
  localparam int unsigned TW    = $clog2(TILE);
  localparam int unsigned LAST  = CELLS - 1;

  fsm_t              fsm;
  logic [IW-1:0]     init_idx;
  logic [CODE_W-1:0] rom_code;

  logic [CODE_W-1:0] ram [CELLS];
  logic [CODE_W-1:0] rd_code;

  logic              wr_in_range_c;
  logic              wr_fire_c;
  logic              we_c;
  logic [IW-1:0]     wa_c;
  logic [CODE_W-1:0] wd_c;

  logic [AW-1:0]     x_c;
  logic [AW-1:0]     y_c;
  logic [AW-1:0]     rx_c;
  logic [AW-1:0]     ry_c;
  logic              in_win_c;
  logic [TW-1:0]     ox_c;
  logic [TW-1:0]     oy_c;
  logic [IW-1:0]     rd_idx_c;

  logic              s1_valid;
  logic [TW-1:0]     s1_ox;
  logic [TW-1:0]     s1_oy;

  logic [CODE_W-1:0] code_m1_c;
  logic [AW-1:0]     sum_c;

  tilemap_rom #(
    .MAP_W (MAP_W),
    .MAP_H (MAP_H)
  ) u_rom (
    .idx  (init_idx),
    .code (rom_code)
  );

  // Single RAM write port shared by the INIT loader and the run-time writer.
  always_comb begin
    wr_in_range_c = (32'(wr_x) < MAP_W) && (32'(wr_y) < MAP_H);
    wr_fire_c     = wr_valid && wr_ready;
    we_c          = 1'b0;
    wa_c          = init_idx;
    wd_c          = rom_code;
    if (!rst) begin
      if (fsm == INIT) begin
        we_c = 1'b1;
      end else if (wr_fire_c && wr_in_range_c) begin
        we_c = 1'b1;
        wa_c = IW'(32'(wr_y) * MAP_W + 32'(wr_x));
        wd_c = wr_tile;
      end
    end
  end

  // Screen to map coordinates; divisions are by compile-time constants.
  always_comb begin
    x_c      = AW'(h_cnt >> SCALE_SHIFT);
    y_c      = AW'(v_cnt >> SCALE_SHIFT);
    rx_c     = x_c - AW'(ORG_X);
    ry_c     = y_c - AW'(ORG_Y);
    in_win_c = (fsm == RUN) && STAGE_MASK[state] &&
               (x_c >= AW'(ORG_X)) && (x_c < AW'(ORG_X + MAP_W * TILE)) &&
               (y_c >= AW'(ORG_Y)) && (y_c < AW'(ORG_Y + MAP_H * TILE));
    ox_c     = TW'(rx_c % AW'(TILE));
    oy_c     = TW'(ry_c % AW'(TILE));
    rd_idx_c = '0;
    if (in_win_c) begin
      rd_idx_c = IW'((ry_c / AW'(TILE)) * AW'(MAP_W) + rx_c / AW'(TILE));
    end
  end

  always_comb begin
    code_m1_c = rd_code - CODE_W'(1);
    sum_c     = AW'(TEX_BASE_X) + AW'(code_m1_c) * AW'(TILE) + AW'(s1_ox) +
                (AW'(TEX_BASE_Y) + AW'(s1_oy)) * AW'(TEX_W);
  end

  // Synchronous read-first RAM: a same-edge write is not visible to the read.
  always_ff @(posedge clk) begin
    if (we_c) ram[wa_c] <= wd_c;
    rd_code <= ram[rd_idx_c];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= INIT;
      init_idx  <= '0;
      init_done <= 1'b0;
      wr_ready  <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      wr_err <= 1'b0;
      case (fsm)
        INIT: begin
          if (init_idx == IW'(LAST)) begin
            fsm       <= RUN;
            init_done <= 1'b1;
            wr_ready  <= 1'b1;
          end else begin
            init_idx <= init_idx + IW'(1);
          end
        end
        RUN: begin
          wr_err <= wr_fire_c && !wr_in_range_c;
        end
      endcase
    end
  end

  // Stage 1 holds window/offsets alongside the RAM read; stage 2 forms the address.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_ox      <= '0;
      s1_oy      <= '0;
      isObject   <= 1'b0;
      pixel_addr <= '0;
    end else begin
      s1_valid <= in_win_c;
      s1_ox    <= ox_c;
      s1_oy    <= oy_c;
      if (s1_valid && (rd_code != FLOOR)) begin
        isObject   <= 1'b1;
        pixel_addr <= 17'(sum_c % AW'(TEX_DEPTH));
      end else begin
        isObject   <= 1'b0;
        pixel_addr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_draw_tilemap.sv
// Bench for draw_tilemap: directed corner cases plus randomized pixels/writes
// against a cell-array reference model.
module tb_draw_tilemap;
  import tilemap_pkg::*;

  logic        clk;
  logic        rst;
  logic [3:0]  state;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic        wr_valid;
  logic        wr_ready;
  logic [5:0]  wr_x;
  logic [5:0]  wr_y;
  logic [1:0]  wr_tile;
  logic        wr_err;
  logic        init_done;
  logic [16:0] pixel_addr;
  logic        isObject;

  int n_checks;
  int n_errors;
  int tmap [41][41];

  draw_tilemap dut (
    .clk        (clk),
    .rst        (rst),
    .state      (state),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .wr_tile    (wr_tile),
    .wr_err     (wr_err),
    .init_done  (init_done),
    .pixel_addr (pixel_addr),
    .isObject   (isObject)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int default_code(input int cx, input int cy);
    if (cx == 40 && cy >= 19 && cy <= 21) return 0;
    if (cx == 0 || cy == 0 || cx == 40 || cy == 40) return 1;
    if (cx % 3 == 0 && cy % 3 == 0) return 1;
    return 0;
  endfunction

  task automatic reset_model();
    for (int cx = 0; cx < 41; cx++)
      for (int cy = 0; cy < 41; cy++)
        tmap[cx][cy] = default_code(cx, cy);
  endtask

  function automatic void ref_pixel(input int h, input int v, input int st,
                                    output int obj, output int addr);
    int x, y, cx, cy, ox, oy, c;
    obj  = 0;
    addr = 0;
    x = h >> 1;
    y = v >> 1;
    if (((32'h54 >> st) & 1) == 0) return;
    if (x < 60 || x >= 60 + 41 * 5 || y < 30 || y >= 30 + 41 * 5) return;
    cx = (x - 60) / 5;
    cy = (y - 30) / 5;
    ox = (x - 60) % 5;
    oy = (y - 30) % 5;
    c  = tmap[cx][cy];
    if (c == 0) return;
    obj  = 1;
    addr = (330 + (c - 1) * 5 + ox + (30 + oy) * 360) % 86400;
  endfunction

  task automatic set_pix(input int h, input int v, input int st);
    h_cnt = 10'(h);
    v_cnt = 10'(v);
    state = 4'(st);
  endtask

  task automatic probe(input string tag, input int h, input int v, input int st,
                       input int eo, input int ea);
    @(negedge clk);
    set_pix(h, v, st);
    @(negedge clk);
    @(negedge clk);
    check_val({tag, "_obj"}, 32'(isObject), 32'(eo));
    check_val({tag, "_addr"}, 32'(pixel_addr), 32'(ea));
  endtask

  task automatic do_write(input string tag, input int wx, input int wy, input int wt);
    bit oor;
    oor = (wx >= 41) || (wy >= 41);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_x     = 6'(wx);
    wr_y     = 6'(wy);
    wr_tile  = 2'(wt);
    @(negedge clk);
    wr_valid = 1'b0;
    check_val({tag, "_err"}, 32'(wr_err), 32'(oor));
    if (!oor) tmap[wx][wy] = wt;
    @(negedge clk);
    check_val({tag, "_err_clr"}, 32'(wr_err), 0);
  endtask

  // Caller releases rst at a negedge; counts edges until init_done is seen.
  task automatic count_init(input string tag);
    int cycles;
    bit saw_rdy;
    bit saw_obj;
    cycles  = 0;
    saw_rdy = 1'b0;
    saw_obj = 1'b0;
    while (cycles < 3000) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (init_done === 1'b1) break;
      if (wr_ready !== 1'b0) saw_rdy = 1'b1;
      if (isObject !== 1'b0 || pixel_addr !== 17'd0) saw_obj = 1'b1;
    end
    wr_valid = 1'b0;
    check_val({tag, "_cycles"}, 32'(cycles), 1681);
    check_val({tag, "_ready_now"}, 32'(wr_ready), 1);
    check_val({tag, "_ready_early"}, 32'(saw_rdy), 0);
    check_val({tag, "_pix_quiet"}, 32'(saw_obj), 0);
  endtask

  initial begin
    int q_obj[$];
    int q_addr[$];
    int exp_err;
    int h, v, st, wx, wy, wt, eo, ea;
    bit wv;
    bit saw_done;

    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_x     = '0;
    wr_y     = '0;
    wr_tile  = '0;
    set_pix(0, 0, 0);
    repeat (3) @(negedge clk);

    check_val("rst_wr_ready", 32'(wr_ready), 0);
    check_val("rst_wr_err", 32'(wr_err), 0);
    check_val("rst_init_done", 32'(init_done), 0);
    check_val("rst_isObject", 32'(isObject), 0);
    check_val("rst_pixel_addr", 32'(pixel_addr), 0);

    // Write held during INIT must be ignored; wall pixel must stay dark.
    wr_valid = 1'b1;
    wr_x     = 6'd1;
    wr_y     = 6'd1;
    wr_tile  = WALL;
    set_pix(120, 60, 2);
    rst = 1'b0;
    count_init("init1");
    reset_model();

    probe("wall00", 120, 60, 2, 1, 11130);
    probe("wall00_st3", 120, 60, 3, 0, 0);
    probe("wall00_st6", 120, 60, 6, 1, 11130);
    probe("floor11", 130, 70, 2, 0, 0);
    probe("floor11_st3", 130, 70, 3, 0, 0);
    probe("pillar33_off", 154, 96, 4, 1, 12212);
    probe("floor23", 140, 90, 2, 0, 0);
    probe("corner4040", 528, 468, 2, 1, 12574);
    probe("right_edge", 530, 468, 2, 0, 0);
    probe("left_edge", 118, 60, 2, 0, 0);
    probe("top_edge", 120, 58, 2, 0, 0);
    probe("exit_gap", 520, 260, 2, 0, 0);
    probe("east_wall18", 520, 240, 2, 1, 11130);

    do_write("wr11_locked", 1, 1, DOOR_LOCKED);
    probe("door_locked", 130, 70, 2, 1, 11135);
    do_write("wr11_open", 1, 1, DOOR_OPEN);
    probe("door_open", 130, 70, 2, 1, 11140);
    probe("door_open_st7", 130, 70, 7, 0, 0);

    do_write("wr_oor_x", 41, 0, WALL);
    do_write("wr_oor_x1", 41, 1, DOOR_OPEN);
    do_write("wr_oor_y", 2, 45, DOOR_OPEN);
    probe("cell01_intact", 120, 70, 2, 1, 11130);
    probe("cell02_intact", 120, 80, 2, 1, 11130);

    // Write to (0,0) on the same edge as its stage-1 read.
    @(negedge clk);
    set_pix(120, 60, 2);
    wr_valid = 1'b1;
    wr_x     = 6'd0;
    wr_y     = 6'd0;
    wr_tile  = DOOR_OPEN;
    @(negedge clk);
    wr_valid = 1'b0;
    @(negedge clk);
    check_val("collide_old", 32'(pixel_addr), 11130);
    tmap[0][0] = 3;
    @(negedge clk);
    check_val("collide_new", 32'(pixel_addr), 11140);

    // Randomized pixels and writes against the reference model.
    exp_err = 0;
    for (int i = 0; i < 1502; i++) begin
      @(negedge clk);
      check_val("rnd_wr_err", 32'(wr_err), 32'(exp_err));
      if (i >= 2) begin
        check_val("rnd_obj", 32'(isObject), 32'(q_obj.pop_front()));
        check_val("rnd_addr", 32'(pixel_addr), 32'(q_addr.pop_front()));
      end
      if (i < 1500) begin
        wv = ($urandom_range(0, 2) == 0);
        wx = $urandom_range(0, 43);
        wy = $urandom_range(0, 42);
        wt = $urandom_range(0, 3);
        st = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : 2 * $urandom_range(1, 3);
        if ($urandom_range(0, 3) == 0 && wx < 41 && wy < 41) begin
          h = 2 * (60 + 5 * wx + $urandom_range(0, 4)) + $urandom_range(0, 1);
          v = 2 * (30 + 5 * wy + $urandom_range(0, 4)) + $urandom_range(0, 1);
        end else begin
          h = $urandom_range(100, 560);
          v = $urandom_range(40, 500);
        end
        set_pix(h, v, st);
        wr_valid = wv;
        wr_x     = 6'(wx);
        wr_y     = 6'(wy);
        wr_tile  = 2'(wt);
        ref_pixel(h, v, st, eo, ea);
        q_obj.push_back(eo);
        q_addr.push_back(ea);
        exp_err = (wv && (wx >= 41 || wy >= 41)) ? 1 : 0;
        if (wv && wx < 41 && wy < 41) tmap[wx][wy] = wt;
      end else begin
        wr_valid = 1'b0;
        set_pix(0, 0, 0);
        exp_err = 0;
      end
    end

    // Reset in RUN, then again mid-INIT at cycle 800: INIT restarts from cell 0.
    @(negedge clk);
    rst      = 1'b1;
    wr_valid = 1'b1;
    wr_x     = 6'd1;
    wr_y     = 6'd1;
    wr_tile  = DOOR_LOCKED;
    set_pix(120, 60, 2);
    @(negedge clk);
    rst      = 1'b0;
    saw_done = 1'b0;
    repeat (800) begin
      @(posedge clk);
      @(negedge clk);
      if (init_done !== 1'b0) saw_done = 1'b1;
    end
    check_val("mid_init_done_low", 32'(saw_done), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    count_init("init2");
    reset_model();
    probe("restart_cell11", 130, 70, 2, 0, 0);
    probe("restart_cell00", 120, 60, 2, 1, 11130);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
